// File: rtl/pwm_preconditioner.sv
// ---------------------------------------------------------------------------
// pwm_preconditioner
//
// Converts the silenced per-transducer DUTY/PHASE arrays plus the
// per-transducer PWM period into RISE/FALL edge times for the PWM generator.
// One transducer is processed per clock through a 3-stage pipeline whose
// last stage writes a shadow buffer. Once all DEPTH entries are in the
// shadow buffer, every result is published to the outputs on the same edge
// as a one-cycle DONE pulse, so the outputs never show a partial update.
//
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   i_start  one-cycle pulse that begins a pass (ignored unless idle)
//   i_cycle  per-transducer PWM period                  [DEPTH][WIDTH]
//   i_duty   per-transducer silenced duty               [DEPTH][WIDTH]
//   i_phase  per-transducer silenced phase              [DEPTH][WIDTH]
//   o_rise   rising-edge time, range [0, CYCLE-1]       [DEPTH][WIDTH]
//   o_fall   falling-edge time, range [0, CYCLE]        [DEPTH][WIDTH]
//   o_done   one-cycle pulse, o_rise/o_fall update on the same edge
//
// Timing: transducer i is sampled in cycle T0+1+i (T0 = cycle i_start is
// sampled); o_done rises DEPTH+4 cycles after T0.
// ---------------------------------------------------------------------------
module pwm_preconditioner #(
   parameter int WIDTH = 13,
   parameter int DEPTH = 249
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   input  logic                         i_start,
   input  logic [DEPTH-1:0][WIDTH-1:0]  i_cycle,
   input  logic [DEPTH-1:0][WIDTH-1:0]  i_duty,
   input  logic [DEPTH-1:0][WIDTH-1:0]  i_phase,
   output logic [DEPTH-1:0][WIDTH-1:0]  o_rise,
   output logic [DEPTH-1:0][WIDTH-1:0]  o_fall,
   output logic                         o_done
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int SW = WIDTH + 2;
   localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      DRAIN   = 2'd2,
      PUBLISH = 2'd3
   } state_t;

   state_t r_state;
   state_t w_state_nxt;
   logic   w_run;
   logic   w_publish;

   logic [IW-1:0]    r_idx;

   // stage 1 registers
   logic             r_v1;
   logic [IW-1:0]    r_idx1;
   logic [WIDTH-1:0] r_c1;
   logic [WIDTH-1:0] r_d1;
   logic [WIDTH-1:0] r_p1;

   // stage 2 registers
   logic                 r_v2;
   logic [IW-1:0]        r_idx2;
   logic [WIDTH-1:0]     r_c2;
   logic signed [SW-1:0] r_r2;
   logic signed [SW-1:0] r_f2;
   logic                 r_zero2;
   logic                 r_full2;

   // shadow buffer
   logic [DEPTH-1:0][WIDTH-1:0] r_sh_rise;
   logic [DEPTH-1:0][WIDTH-1:0] r_sh_fall;

   // stage 1 combinational inputs
   logic [WIDTH-1:0] w_c_in;
   logic [WIDTH-1:0] w_d_in;
   logic [WIDTH-1:0] w_p_in;
   logic [WIDTH-1:0] w_d_clamp;
   logic [WIDTH-1:0] w_p_wrap;

   // stage 2 combinational values
   logic [WIDTH-1:0]     w_half_lo;
   logic [WIDTH-1:0]     w_half_hi;
   logic signed [SW-1:0] w_r2;
   logic signed [SW-1:0] w_f2;

   // stage 3 combinational values
   logic signed [SW-1:0] w_c3;
   logic [WIDTH-1:0]     w_r3;
   logic [WIDTH-1:0]     w_f3;
   logic [WIDTH-1:0]     w_rise_wr;
   logic [WIDTH-1:0]     w_fall_wr;

   // FSM state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state logic; START outside IDLE is deliberately dropped
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_state_nxt = RUN;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         RUN: begin
            if (r_idx == LAST_IDX) begin
               w_state_nxt = DRAIN;
            end else begin
               w_state_nxt = RUN;
            end
         end
         DRAIN: begin
            if (!r_v1 && !r_v2) begin
               w_state_nxt = PUBLISH;
            end else begin
               w_state_nxt = DRAIN;
            end
         end
         PUBLISH: w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // FSM output decode
   always_comb begin
      w_run     = 1'b0;
      w_publish = 1'b0;
      case (r_state)
         RUN:     w_run     = 1'b1;
         PUBLISH: w_publish = 1'b1;
         default: begin
            w_run     = 1'b0;
            w_publish = 1'b0;
         end
      endcase
   end

   // issue index: counts through the transducers while running, 0 otherwise
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_idx <= '0;
      end else if (w_run && (r_idx != LAST_IDX)) begin
         r_idx <= r_idx + IW'(1);
      end else begin
         r_idx <= '0;
      end
   end

   // stage 1: clamp duty to the period and fold phase with one subtraction
   assign w_c_in    = i_cycle[r_idx];
   assign w_d_in    = i_duty[r_idx];
   assign w_p_in    = i_phase[r_idx];
   assign w_d_clamp = (w_d_in > w_c_in) ? w_c_in : w_d_in;
   assign w_p_wrap  = (w_p_in >= w_c_in) ? (w_p_in - w_c_in) : w_p_in;

   // stage 1 registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_v1   <= 1'b0;
         r_idx1 <= '0;
         r_c1   <= '0;
         r_d1   <= '0;
         r_p1   <= '0;
      end else begin
         r_v1 <= w_run;
         if (w_run) begin
            r_idx1 <= r_idx;
            r_c1   <= w_c_in;
            r_d1   <= w_d_clamp;
            r_p1   <= w_p_wrap;
         end
      end
   end

   // stage 2: centre the pulse on the phase; odd duty puts the extra count
   // on the falling side
   assign w_half_lo = r_d1 >> 1;
   assign w_half_hi = r_d1 - w_half_lo;
   assign w_r2 = signed'(SW'(r_p1)) - signed'(SW'(w_half_lo));
   assign w_f2 = signed'(SW'(r_p1)) + signed'(SW'(w_half_hi));

   // stage 2 registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_v2    <= 1'b0;
         r_idx2  <= '0;
         r_c2    <= '0;
         r_r2    <= '0;
         r_f2    <= '0;
         r_zero2 <= 1'b0;
         r_full2 <= 1'b0;
      end else begin
         r_v2 <= r_v1;
         if (r_v1) begin
            r_idx2  <= r_idx1;
            r_c2    <= r_c1;
            r_r2    <= w_r2;
            r_f2    <= w_f2;
            r_zero2 <= (r_d1 == '0);
            r_full2 <= (r_d1 == r_c1);
         end
      end
   end

   // stage 3: wrap edges back into [0, c) and apply the never/always-high
   // special cases
   assign w_c3 = signed'(SW'(r_c2));
   assign w_r3 = WIDTH'(r_r2[SW-1] ? (r_r2 + w_c3) : r_r2);
   assign w_f3 = WIDTH'((r_f2 >= w_c3) ? (r_f2 - w_c3) : r_f2);
   assign w_rise_wr = (r_zero2 || r_full2) ? '0 : w_r3;
   assign w_fall_wr = r_zero2 ? '0 : (r_full2 ? r_c2 : w_f3);

   // shadow buffer write from stage 3
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sh_rise <= '0;
         r_sh_fall <= '0;
      end else if (r_v2) begin
         r_sh_rise[r_idx2] <= w_rise_wr;
         r_sh_fall[r_idx2] <= w_fall_wr;
      end
   end

   // atomic publish of the whole shadow buffer together with DONE
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_rise <= '0;
         o_fall <= '0;
         o_done <= 1'b0;
      end else begin
         o_done <= w_publish;
         if (w_publish) begin
            o_rise <= r_sh_rise;
            o_fall <= r_sh_fall;
         end
      end
   end

endmodule

// File: tb/tb_pwm_preconditioner.sv
module tb_pwm_preconditioner;

   localparam int WIDTH = 13;
   localparam int DEPTH = 249;
   localparam int LAT   = DEPTH + 4;

   logic clk;
   logic rst_n;
   logic start;
   logic [DEPTH-1:0][WIDTH-1:0] cyc_a;
   logic [DEPTH-1:0][WIDTH-1:0] duty_a;
   logic [DEPTH-1:0][WIDTH-1:0] phase_a;
   logic [DEPTH-1:0][WIDTH-1:0] o_rise;
   logic [DEPTH-1:0][WIDTH-1:0] o_fall;
   logic o_done;

   int vecs  = 0;
   int fails = 0;
   int exp_r [DEPTH];
   int exp_f [DEPTH];
   int done_at, done_cnt, changes;

   pwm_preconditioner #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_start (start),
      .i_cycle (cyc_a),
      .i_duty  (duty_a),
      .i_phase (phase_a),
      .o_rise  (o_rise),
      .o_fall  (o_fall),
      .o_done  (o_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      vecs++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference: edges as modular offsets around the folded phase.
   function automatic void model(input int c, input int duty, input int phase,
                                 output int r, output int f);
      int d, p, lo;
      d  = (duty > c) ? c : duty;
      p  = (phase >= c) ? phase - c : phase;
      lo = d / 2;
      if (d == 0) begin
         r = 0; f = 0;
      end else if (d == c) begin
         r = 0; f = c;
      end else begin
         r = (((p - lo) % c) + c) % c;
         f = (p + (d - lo)) % c;
      end
   endfunction

   task automatic fill_random();
      int c, dt, ph, lim, r, f;
      for (int i = 0; i < DEPTH; i++) begin
         c   = int'($urandom_range(8000, 2000));
         dt  = int'($urandom_range(c + 300, 0));
         lim = (2 * c - 1 > 8191) ? 8191 : 2 * c - 1;
         ph  = int'($urandom_range(lim, 0));
         cyc_a[i]   = WIDTH'(c);
         duty_a[i]  = WIDTH'(dt);
         phase_a[i] = WIDTH'(ph);
         model(c, dt, ph, r, f);
         exp_r[i] = r;
         exp_f[i] = f;
      end
   endtask

   task automatic set_tr(input int i, input int dt, input int ph, input int er, input int ef);
      cyc_a[i]   = 13'd4096;
      duty_a[i]  = WIDTH'(dt);
      phase_a[i] = WIDTH'(ph);
      exp_r[i]   = er;
      exp_f[i]   = ef;
   endtask

   task automatic fill_directed();
      for (int i = 0; i < DEPTH; i++) set_tr(i, 0, 0, 0, 0);
      set_tr(0,   2048, 1024,    0, 2048);
      set_tr(1,   1000,  100, 3696,  600);
      set_tr(2,   4000, 4000, 2000, 1904);
      set_tr(3,   1001, 2000, 1500, 2501);
      set_tr(4,      0,  500,    0,    0);
      set_tr(5,   4096,  300,    0, 4096);
      set_tr(6,   5000,  300,    0, 4096);
      set_tr(7,      0, 4100,    0,    0);
      set_tr(8,      2, 4100,    3,    5);
      set_tr(248, 2048, 1024,    0, 2048);
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < DEPTH; i++) begin
         chk($sformatf("%s_rise[%0d]", tag, i), int'(o_rise[i]), exp_r[i]);
         chk($sformatf("%s_fall[%0d]", tag, i), int'(o_fall[i]), exp_f[i]);
      end
   endtask

   // One pass: pulse START, then watch 300 cycles counted from T0.
   task automatic run_pass(input int extra_at, input int rst_at,
                           output int d_at, output int d_cnt, output int chg);
      logic [DEPTH-1:0][WIDTH-1:0] snap_r, snap_f;
      @(negedge clk);
      start  = 1'b1;
      snap_r = o_rise;
      snap_f = o_fall;
      @(negedge clk);
      start = 1'b0;
      d_at  = -1;
      d_cnt = 0;
      chg   = 0;
      for (int k = 1; k <= 300; k++) begin
         @(negedge clk);
         if (start) start = 1'b0;
         if (o_done) begin
            d_cnt++;
            if (d_at < 0) d_at = k;
            snap_r = o_rise;
            snap_f = o_fall;
         end else if ((o_rise !== snap_r) || (o_fall !== snap_f)) begin
            chg++;
         end
         if (k == extra_at) start = 1'b1;
         if (rst_at > 0 && k == rst_at) rst_n = 1'b0;
         if (rst_at > 0 && k == rst_at + 3) rst_n = 1'b1;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      fill_directed();
      repeat (3) @(negedge clk);
      chk("reset_done", int'(o_done), 0);
      chk("reset_rise_zero", int'(o_rise == '0), 1);
      chk("reset_fall_zero", int'(o_fall == '0), 1);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // directed boundary vectors
      run_pass(-1, -1, done_at, done_cnt, changes);
      chk("dir_done_latency", done_at, LAT);
      chk("dir_done_count", done_cnt, 1);
      chk("dir_stable", changes, 0);
      check_all("dir");

      // random pass against the model
      fill_random();
      run_pass(-1, -1, done_at, done_cnt, changes);
      chk("rand_done_latency", done_at, LAT);
      chk("rand_done_count", done_cnt, 1);
      chk("rand_stable", changes, 0);
      check_all("rand");

      // second START mid-pass is ignored
      fill_random();
      run_pass(50, -1, done_at, done_cnt, changes);
      chk("restart_done_latency", done_at, LAT);
      chk("restart_done_count", done_cnt, 1);
      chk("restart_stable", changes, 0);
      check_all("restart");

      // reset mid-pass aborts and zeroes
      fill_random();
      run_pass(-1, 100, done_at, done_cnt, changes);
      chk("abort_done_count", done_cnt, 0);
      chk("abort_rise_zero", int'(o_rise == '0), 1);
      chk("abort_fall_zero", int'(o_fall == '0), 1);

      // fresh pass after reset release
      fill_directed();
      run_pass(-1, -1, done_at, done_cnt, changes);
      chk("after_rst_done_latency", done_at, LAT);
      chk("after_rst_done_count", done_cnt, 1);
      check_all("after_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule
